mmio_interconnect: RTL and testbench
====================================

Name: mmio_interconnect

Overview:
Parametrised memory-mapped bus interconnect between the multicycle CPU memory port and N MMIO slaves (BRAM, GPIO, future SPI flash/UART).
- Decodes memAddress against per-slave inclusive address windows.
- Gates write strobes to the selected slave only.
- Returns read data through a select pipeline whose depth matches slave read latency.
- Detects unmapped accesses with a sticky error flag, fault capture and a fault counter.

Parameters:
- NUM_SLAVES, 2, number of slave channels (1..8).
- BASE_ADDRS, {32'hFFFF_FFF0, 32'h0000_0000}, packed NUM_SLAVES*32 base addresses; slave i occupies bits [32*i+:32].
- TOP_ADDRS, {32'hFFFF_FFF3, 32'h0000_07FF}, packed NUM_SLAVES*32 inclusive top addresses.
- READ_LATENCY, 1, cycles from access to slave read data valid (1..4).
- DEFAULT_READ, 32'h0000_0000, read data returned for unmapped or idle accesses.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- memAddress  in  32  CPU byte address
- memValid  in  1  CPU access strobe, read or write, this cycle
- memWrite  in  1  write qualifier; meaningful only with memValid=1
- memReadData  out  32  read data to CPU
- slaveSel  out  NUM_SLAVES  one-hot combinational select of the current access
- slaveWrite  out  NUM_SLAVES  one-hot write strobe to slaves
- slaveReadData  in  NUM_SLAVES*32  packed slave read data, slave i at [32*i+:32]
- errClear  in  1  synchronous clear of error state
- busError  out  1  sticky unmapped-access flag
- faultAddress  out  32  address of first unmapped access since clear
- faultWrite  out  1  first fault was a write
- faultCount  out  8  saturating count of unmapped accesses

Behaviour:
- Decode: hit_i = (memAddress >= BASE_i) && (memAddress <= TOP_i), unsigned and inclusive. Overlapping windows resolve to the lowest index. Unmapped means no hit_i.
- slaveSel = one-hot hit, gated by memValid. All zero when memValid=0 or unmapped. Combinational, zero latency.
- slaveWrite = slaveSel & {NUM_SLAVES{memWrite}}. No strobe reaches any slave for an unmapped write.
- Read select pipeline: READ_LATENCY stages of {valid, idx}. Stage 0 captures {memValid && mapped && !memWrite, selected index} on every clk edge; each stage shifts every cycle with no stall.
- memReadData = slaveReadData[idx] of the last stage if its valid=1, else DEFAULT_READ. The mux is combinational on the registered select.
  - A read issued in cycle t is returned during cycle t+READ_LATENCY.
  - Back-to-back reads to different slaves are each returned correctly.
- Fault: a clk edge with memValid=1 and unmapped does all of the following:
  - sets busError=1;
  - increments faultCount, saturating at 255;
  - if busError was 0 before the edge, captures faultAddress<=memAddress and faultWrite<=memWrite. Later faults do not overwrite the capture.
- errClear=1 at an edge: busError<=0, faultCount<=0. faultAddress/faultWrite hold their values.
- errClear and a new fault at the same edge: the fault wins. Result is busError=1, faultCount=1, and the new address is captured.
- Reset values, applied immediately on reset asserting:
  - all pipeline stages valid=0, so memReadData=DEFAULT_READ;
  - busError=0, faultCount=0, faultAddress=0, faultWrite=0.
  - slaveSel/slaveWrite remain combinational from the inputs.
- Reset mid-read: the pending read is dropped and DEFAULT_READ is returned; the CPU is reset on the same signal.
- Elaboration check: fatal error if any BASE_i > TOP_i or READ_LATENCY is outside 1..4.

Decomposition:
- Package mmio_pkg:
  - ADDR_W=32, DATA_W=32;
  - addr_range_t struct {base, top};
  - standard map constants BRAM_BASE=32'h0000_0000, BRAM_TOP=32'h0000_07FF, GPIO_BASE=32'hFFFF_FFF0, GPIO_TOP=32'hFFFF_FFF3;
  - MAX_SLAVES=8.
- One sub-module, mmio_addr_decode: purely combinational address-to-{mapped, idx, onehot} with lowest-index priority. The pipeline and fault logic stay in mmio_interconnect.

Test Plan:
- Read BRAM and GPIO (defaults, READ_LATENCY=1): read 0x0000_0010 with slave0 data 0xDEADBEEF, then 0xFFFF_FFF0 with slave1 data 0x0000_0005 in the next cycle -> memReadData is 0xDEADBEEF, then 0x00000005, each one cycle after issue.
- Write gating: memValid=1, memWrite=1 to 0xFFFF_FFF2 -> slaveWrite=2'b10 same cycle. Same write to 0x0000_0800 -> slaveWrite=2'b00 and busError=1 next cycle.
- Fault capture and count: unmapped read at 0x1000_0000, then unmapped write at 0x2000_0000 -> faultAddress=0x1000_0000, faultWrite=0, faultCount=2. After 300 unmapped accesses faultCount=255.
- Clear race: errClear=1 at the same edge as an unmapped access to 0x3000_0000 -> busError=1, faultCount=1, faultAddress=0x3000_0000.
- Latency 3: READ_LATENCY=3, NUM_SLAVES=3, three back-to-back reads to slaves 2, 0, 1 -> data returned in issue order at t+3, t+4, t+5. An idle cycle returns 0.
- Reset mid-read: assert reset one cycle after a BRAM read issue -> memReadData=0 immediately, busError=0, faultCount=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect: bus widths, address window
// record, and the standard BRAM/GPIO memory map.
package mmio_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_SLAVES = 8;
  localparam int IDX_W      = $clog2(MAX_SLAVES);

  localparam logic [ADDR_W-1:0] BRAM_BASE = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] BRAM_TOP  = 32'h0000_07FF;
  localparam logic [ADDR_W-1:0] GPIO_BASE = 32'hFFFF_FFF0;
  localparam logic [ADDR_W-1:0] GPIO_TOP  = 32'hFFFF_FFF3;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] top;
  } addr_range_t;

  // Unsigned, inclusive window test.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input addr_range_t rng);
    return (addr >= rng.base) && (addr <= rng.top);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder: maps an address onto the slave windows, the lowest
// slave index winning where windows overlap.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                           NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = {GPIO_BASE, BRAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] TOP_ADDRS  = {GPIO_TOP, BRAM_TOP}
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  mapped_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic [NUM_SLAVES-1:0] onehot_o
);

  addr_range_t rng_s;
  logic        hit_s;

  // Scan from the highest index down so the lowest hitting slave is written last.
  always_comb begin
    rng_s    = '0;
    hit_s    = 1'b0;
    mapped_o = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      rng_s.base = BASE_ADDRS[ADDR_W*i +: ADDR_W];
      rng_s.top  = TOP_ADDRS[ADDR_W*i +: ADDR_W];
      hit_s      = in_range(addr_i, rng_s);
      mapped_o   = mapped_o | hit_s;
      idx_o      = hit_s ? IDX_W'(i) : idx_o;
      onehot_o   = hit_s ? (NUM_SLAVES'(1) << i) : onehot_o;
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// CPU-to-MMIO interconnect: window decode, write-strobe gating, fixed-latency read
// return pipeline and sticky unmapped-access fault capture.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int                           NUM_SLAVES   = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS   = {GPIO_BASE, BRAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] TOP_ADDRS    = {GPIO_TOP, BRAM_TOP},
  parameter int                           READ_LATENCY = 1,
  parameter logic [DATA_W-1:0]            DEFAULT_READ = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            memAddress,
  input  logic                         memValid,
  input  logic                         memWrite,
  output logic [DATA_W-1:0]            memReadData,
  output logic [NUM_SLAVES-1:0]        slaveSel,
  output logic [NUM_SLAVES-1:0]        slaveWrite,
  input  logic [NUM_SLAVES*DATA_W-1:0] slaveReadData,
  input  logic                         errClear,
  output logic                         busError,
  output logic [ADDR_W-1:0]            faultAddress,
  output logic                         faultWrite,
  output logic [7:0]                   faultCount
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_num
    $fatal(1, "mmio_interconnect: NUM_SLAVES must be 1..8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $fatal(1, "mmio_interconnect: READ_LATENCY must be 1..4");
  end
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_chk_win
    if (BASE_ADDRS[ADDR_W*g +: ADDR_W] > TOP_ADDRS[ADDR_W*g +: ADDR_W]) begin : g_bad_win
      $fatal(1, "mmio_interconnect: slave window base above top");
    end
  end

  logic                  mapped_s;
  logic [IDX_W-1:0]      idx_s;
  logic [NUM_SLAVES-1:0] onehot_s;
  logic                  fault_s;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDRS (BASE_ADDRS),
    .TOP_ADDRS  (TOP_ADDRS)
  ) u_decode (
    .addr_i   (memAddress),
    .mapped_o (mapped_s),
    .idx_o    (idx_s),
    .onehot_o (onehot_s)
  );

  assign slaveSel   = memValid ? onehot_s : '0;
  assign slaveWrite = slaveSel & {NUM_SLAVES{memWrite}};
  assign fault_s    = memValid & ~mapped_s;

  logic [READ_LATENCY-1:0]            pv_q, pv_d;
  logic [READ_LATENCY-1:0][IDX_W-1:0] pidx_q, pidx_d;
  logic [DATA_W-1:0]                  rd_s;

  // Read select pipeline: stage 0 takes the new access, later stages shift unconditionally.
  always_comb begin
    pv_d      = '0;
    pidx_d    = '0;
    pv_d[0]   = memValid & mapped_s & ~memWrite;
    pidx_d[0] = idx_s;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i]   = pv_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end
  end

  // Pipeline registers; reset drops any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q   <= '0;
      pidx_q <= '0;
    end else begin
      pv_q   <= pv_d;
      pidx_q <= pidx_d;
    end
  end

  // Return mux driven from the registered last stage.
  always_comb begin
    rd_s = DEFAULT_READ;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rd_s = (pv_q[READ_LATENCY-1] && (pidx_q[READ_LATENCY-1] == IDX_W'(i)))
             ? slaveReadData[DATA_W*i +: DATA_W] : rd_s;
    end
  end

  assign memReadData = rd_s;

  logic              berr_q, berr_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic              fwr_q, fwr_d;
  logic [7:0]        fcnt_q, fcnt_d;

  // Fault state: a fault at the same edge as errClear restarts the record from this fault.
  always_comb begin
    berr_d  = berr_q;
    faddr_d = faddr_q;
    fwr_d   = fwr_q;
    fcnt_d  = fcnt_q;
    if (fault_s) begin
      berr_d = 1'b1;
      if (errClear || !berr_q) begin
        faddr_d = memAddress;
        fwr_d   = memWrite;
      end else begin
        faddr_d = faddr_q;
        fwr_d   = fwr_q;
      end
      if (errClear) begin
        fcnt_d = 8'd1;
      end else begin
        fcnt_d = (fcnt_q == 8'hFF) ? 8'hFF : fcnt_q + 8'd1;
      end
    end else if (errClear) begin
      berr_d = 1'b0;
      fcnt_d = 8'd0;
    end else begin
      berr_d = berr_q;
      fcnt_d = fcnt_q;
    end
  end

  // Fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      berr_q  <= 1'b0;
      faddr_q <= '0;
      fwr_q   <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      berr_q  <= berr_d;
      faddr_q <= faddr_d;
      fwr_q   <= fwr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign busError     = berr_q;
  assign faultAddress = faddr_q;
  assign faultWrite   = fwr_q;
  assign faultCount   = fcnt_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect: a default 2-slave/latency-1 instance and a
// 3-slave/latency-3 instance, read data checked through per-instance expectation queues.
module tb_mmio_interconnect;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults (BRAM slave 0, GPIO slave 1, latency 1)
  logic [31:0] a_addr, a_rd, a_faddr;
  logic        a_valid, a_write, a_clr, a_berr, a_fwr;
  logic [1:0]  a_sel, a_wr;
  logic [63:0] a_srd;
  logic [7:0]  a_fcnt;

  // Instance B: extra slave 2 at 0x1000_0000..0x1000_00FF, latency 3
  logic [31:0] b_addr, b_rd, b_faddr;
  logic        b_valid, b_write, b_clr, b_berr, b_fwr;
  logic [2:0]  b_sel, b_wr;
  logic [95:0] b_srd;
  logic [7:0]  b_fcnt;

  mmio_interconnect dut (
    .clk(clk), .reset(reset), .memAddress(a_addr), .memValid(a_valid), .memWrite(a_write),
    .memReadData(a_rd), .slaveSel(a_sel), .slaveWrite(a_wr), .slaveReadData(a_srd),
    .errClear(a_clr), .busError(a_berr), .faultAddress(a_faddr), .faultWrite(a_fwr),
    .faultCount(a_fcnt)
  );

  mmio_interconnect #(
    .NUM_SLAVES(3),
    .BASE_ADDRS({32'h1000_0000, 32'hFFFF_FFF0, 32'h0000_0000}),
    .TOP_ADDRS ({32'h1000_00FF, 32'hFFFF_FFF3, 32'h0000_07FF}),
    .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .reset(reset), .memAddress(b_addr), .memValid(b_valid), .memWrite(b_write),
    .memReadData(b_rd), .slaveSel(b_sel), .slaveWrite(b_wr), .slaveReadData(b_srd),
    .errClear(b_clr), .busError(b_berr), .faultAddress(b_faddr), .faultWrite(b_fwr),
    .faultCount(b_fcnt)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_a(input logic [31:0] addr, input logic v, input logic w);
    if (!v || w)                                     return 32'h0000_0000;
    if (addr <= 32'h0000_07FF)                       return 32'hDEAD_BEEF;
    if (addr >= 32'hFFFF_FFF0 && addr <= 32'hFFFF_FFF3) return 32'h0000_0005;
    return 32'h0000_0000;
  endfunction

  function automatic logic [31:0] model_b(input logic [31:0] addr, input logic v, input logic w);
    if (!v || w)                                     return 32'h0000_0000;
    if (addr <= 32'h0000_07FF)                       return 32'hA0A0_A0A0;
    if (addr >= 32'hFFFF_FFF0 && addr <= 32'hFFFF_FFF3) return 32'hB1B1_B1B1;
    if (addr >= 32'h1000_0000 && addr <= 32'h1000_00FF) return 32'hC2C2_C2C2;
    return 32'h0000_0000;
  endfunction

  // One clock: record what each instance owes, advance, then retire everything due now.
  task automatic tick();
    exp_t e;
    if (!reset) begin
      qa.push_back('{due: cyc + 1, data: model_a(a_addr, a_valid, a_write)});
      qb.push_back('{due: cyc + 3, data: model_b(b_addr, b_valid, b_write)});
    end
    @(posedge clk);
    #1;
    cyc++;
    while (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      chk("rdA", a_rd, e.data);
    end
    while (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      chk("rdB", b_rd, e.data);
    end
  endtask

  task automatic drv_a(input logic [31:0] addr, input logic v, input logic w);
    a_addr = addr; a_valid = v; a_write = w;
    #1;
  endtask

  task automatic drv_b(input logic [31:0] addr, input logic v, input logic w);
    b_addr = addr; b_valid = v; b_write = w;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_addr = 32'h0; a_valid = 1'b0; a_write = 1'b0; a_clr = 1'b0;
    b_addr = 32'h0; b_valid = 1'b0; b_write = 1'b0; b_clr = 1'b0;
    a_srd = {32'h0000_0005, 32'hDEAD_BEEF};
    b_srd = {32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    @(posedge clk);
    #1;
    chk("rst_rdA", a_rd, 32'h0);
    chk("rst_berr", {31'd0, a_berr}, 32'h0);
    chk("rst_fcnt", {24'd0, a_fcnt}, 32'h0);
    chk("rst_faddr", a_faddr, 32'h0);
    chk("rst_fwr", {31'd0, a_fwr}, 32'h0);
    chk("rst_rdB", b_rd, 32'h0);
    reset = 1'b0;

    // Idle with a mapped address: no select.
    drv_a(32'h0000_0010, 1'b0, 1'b0);
    chk("sel_idle", {30'd0, a_sel}, 32'h0);

    // Back-to-back BRAM then GPIO reads, plus inclusive window edges.
    drv_a(32'h0000_0010, 1'b1, 1'b0);
    chk("sel_bram", {30'd0, a_sel}, 32'h1);
    tick();
    drv_a(32'hFFFF_FFF0, 1'b1, 1'b0);
    chk("sel_gpio", {30'd0, a_sel}, 32'h2);
    tick();
    drv_a(32'h0000_07FF, 1'b1, 1'b0);
    chk("sel_bram_top", {30'd0, a_sel}, 32'h1);
    tick();
    drv_a(32'hFFFF_FFF3, 1'b1, 1'b0);
    chk("sel_gpio_top", {30'd0, a_sel}, 32'h2);
    tick();
    drv_a(32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("berr_clean", {31'd0, a_berr}, 32'h0);

    // Write gating: mapped write strobes one slave, unmapped write strobes none.
    drv_a(32'hFFFF_FFF2, 1'b1, 1'b1);
    chk("wr_gpio", {30'd0, a_wr}, 32'h2);
    tick();
    drv_a(32'h0000_0800, 1'b1, 1'b1);
    chk("wr_unmapped", {30'd0, a_wr}, 32'h0);
    chk("sel_unmapped", {30'd0, a_sel}, 32'h0);
    tick();
    chk("berr_set", {31'd0, a_berr}, 32'h1);
    chk("faddr_800", a_faddr, 32'h0000_0800);
    chk("fwr_800", {31'd0, a_fwr}, 32'h1);
    chk("fcnt_1", {24'd0, a_fcnt}, 32'h1);

    // Clear without a fault: flags drop, capture holds.
    drv_a(32'h0, 1'b0, 1'b0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_berr", {31'd0, a_berr}, 32'h0);
    chk("clr_fcnt", {24'd0, a_fcnt}, 32'h0);
    chk("clr_faddr_hold", a_faddr, 32'h0000_0800);

    // First fault captured, later one only counted.
    drv_a(32'h1000_0000, 1'b1, 1'b0);
    tick();
    drv_a(32'h2000_0000, 1'b1, 1'b1);
    tick();
    chk("cap_faddr", a_faddr, 32'h1000_0000);
    chk("cap_fwr", {31'd0, a_fwr}, 32'h0);
    chk("cap_fcnt", {24'd0, a_fcnt}, 32'h2);

    // Saturation: 255 reached after 253 more, then held through 300 total.
    for (int i = 0; i < 253; i++) begin
      drv_a(32'h4000_0000 + i, 1'b1, i[0]);
      tick();
    end
    chk("sat_255", {24'd0, a_fcnt}, 32'd255);
    for (int i = 0; i < 45; i++) begin
      drv_a(32'h5000_0000, 1'b1, 1'b0);
      tick();
    end
    chk("sat_300", {24'd0, a_fcnt}, 32'd255);
    chk("sat_faddr", a_faddr, 32'h1000_0000);

    // Clear racing a new fault: the fault wins.
    drv_a(32'h3000_0000, 1'b1, 1'b0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("race_berr", {31'd0, a_berr}, 32'h1);
    chk("race_fcnt", {24'd0, a_fcnt}, 32'h1);
    chk("race_faddr", a_faddr, 32'h3000_0000);

    // One past GPIO top is unmapped.
    drv_a(32'hFFFF_FFF4, 1'b1, 1'b0);
    chk("sel_gpio_past", {30'd0, a_sel}, 32'h0);
    tick();
    chk("past_fcnt", {24'd0, a_fcnt}, 32'h2);
    chk("past_faddr", a_faddr, 32'h3000_0000);
    drv_a(32'h0, 1'b0, 1'b0);
    tick();

    // Latency 3: reads to slaves 2, 0, 1 back-to-back, then idle.
    drv_b(32'h1000_0004, 1'b1, 1'b0);
    chk("selB_2", {29'd0, b_sel}, 32'h4);
    tick();
    drv_b(32'h0000_0100, 1'b1, 1'b0);
    chk("selB_0", {29'd0, b_sel}, 32'h1);
    tick();
    drv_b(32'hFFFF_FFF1, 1'b1, 1'b0);
    chk("selB_1", {29'd0, b_sel}, 32'h2);
    tick();
    drv_b(32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-read on both instances.
    drv_a(32'h0000_0020, 1'b1, 1'b0);
    drv_b(32'h1000_0000, 1'b1, 1'b0);
    tick();
    drv_a(32'h0, 1'b0, 1'b0);
    drv_b(32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk("mid_rst_rdA", a_rd, 32'h0);
    chk("mid_rst_rdB", b_rd, 32'h0);
    chk("mid_rst_berr", {31'd0, a_berr}, 32'h0);
    chk("mid_rst_fcnt", {24'd0, a_fcnt}, 32'h0);
    chk("mid_rst_faddr", a_faddr, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
